// File: rtl/weight_row_loader.sv
// Pops one weight matrix from Weight_FIFO and streams it to the PE array one
// row per accepted beat, top row (most-significant slice) first.
module weight_row_loader #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int DATA_WIDTH  = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE,
  parameter int ROW_W       = WEIGHT_BW * MATRIX_SIZE,
  parameter int IDX_W       = $clog2(NUM_PE_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic [ROW_W-1:0]      row_data,
  output logic [IDX_W-1:0]      row_index,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic                  busy,
  output logic                  load_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PE_ROWS - 1);

  state_t                state_q;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] shadow_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  rd_en_q;
  logic                  valid_q;
  logic                  done_q;

  // Handshake: a beat transfers on any cycle where row_valid && row_ready;
  // while row_ready is low the beat (data and index) is held unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (start) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          // A start in this very cycle is serviced directly, never queued.
          if ((pending_q || start) && !fifo_empty) begin
            state_q   <= S_READ;
            rd_en_q   <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        S_READ: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          shadow_q <= fifo_data_out;
          cnt_q    <= LAST_ROW;
          valid_q  <= 1'b1;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (row_ready) begin
            if (cnt_q == '0) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_read_enable = rd_en_q;
  assign row_valid        = valid_q;
  assign load_done        = done_q;
  assign row_data         = shadow_q[cnt_q*ROW_W +: ROW_W];
  assign row_index        = cnt_q;
  assign busy             = (state_q != S_IDLE) || pending_q;

endmodule

// File: doc/weight_row_loader.md
# weight_row_loader

Downstream consumer of `Weight_FIFO`: on request, pops one full weight matrix (NUM_PE_ROWS × MATRIX_SIZE × WEIGHT_BW bits) from the FIFO. It then streams it into the PE array one row per accepted beat over a valid/ready handshake. It sits between `Weight_FIFO` and the PE-array weight preload chain and holds one pending load request while busy or while the FIFO is empty.

## Interface
- WEIGHT_BW, 8, bits per weight
- NUM_PE_ROWS, 8, rows per matrix (beats per load)
- MATRIX_SIZE, 8, weights per row
- DATA_WIDTH, WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE (derived), FIFO word width
- ROW_W, WEIGHT_BW*MATRIX_SIZE (derived), row beat width
- IDX_W, $clog2(NUM_PE_ROWS) (derived), row index width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle load request
- fifo_empty  in  1  `Weight_FIFO` empty flag
- fifo_read_enable  out  1  one-cycle pop strobe to `Weight_FIFO`
- fifo_data_out  in  DATA_WIDTH  `Weight_FIFO` read data, valid the cycle after the pop strobe
- row_data  out  ROW_W  current row beat
- row_index  out  IDX_W  PE row number of current beat
- row_valid  out  1  row beat valid
- row_ready  in  1  PE array accepts beat
- busy  out  1  state≠IDLE or request pending
- load_done  out  1  one-cycle pulse after last row accepted

## Operation
- States: IDLE, READ, CAPTURE, SHIFT, DONE.
- pending flag:
  - set by `start` in any state;
  - cleared when entering READ;
  - a `start` while pending is already set has no effect (queue depth 1).
- IDLE → READ when pending (or `start` this cycle) and `fifo_empty`=0. If `fifo_empty`=1, stay in IDLE with pending held.
- READ, one cycle: `fifo_read_enable`=1. Go to CAPTURE.
- CAPTURE, one cycle: latch `fifo_data_out` into a DATA_WIDTH shadow register; row counter = NUM_PE_ROWS-1. Go to SHIFT.
- SHIFT:
  - `row_valid`=1; `row_data` = shadow slice [(cnt+1)*ROW_W-1 : cnt*ROW_W]; `row_index`=cnt.
  - Rows go out most-significant slice first: index NUM_PE_ROWS-1 down to 0.
  - Beat accepted on a cycle with `row_valid`&`row_ready`: decrement cnt.
  - Acceptance at cnt=0 → DONE.
  - `row_ready`=0 holds `row_data` and `row_index` stable.
- DONE, one cycle: `load_done`=1. Go to IDLE; a pending request is serviced from IDLE on the next cycle.
- `fifo_read_enable`, `row_valid` and `load_done` are decoded from the registered state only; none depends combinationally on inputs.
- `fifo_read_enable` is never asserted while `fifo_empty`=1 is sampled in IDLE.
- The module pops exactly one FIFO entry per load.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - state=IDLE, pending=0, shadow=0, cnt=0;
  - all outputs 0: `fifo_read_enable`, `row_valid`, `row_data`, `row_index`, `busy`, `load_done`.
- Reset mid-operation aborts immediately. An entry already popped is discarded and not re-read.
- `start` sampled at edge E with FIFO non-empty, `row_ready` tied high:
  - READ in cycle E+1;
  - CAPTURE in E+2;
  - beats in E+3 … E+2+NUM_PE_ROWS (E+3..E+10 at default);
  - `load_done` in E+11 at default;
  - IDLE in E+12.
- Each row_ready-low cycle during SHIFT adds exactly one cycle of latency.
- `start` coinciding with DONE sets pending; READ follows in the cycle after IDLE.
- Minimum spacing between pops: NUM_PE_ROWS+4 cycles.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with random inputs → all outputs 0, no `fifo_read_enable`.
- Single load, ready high:
  - stimulus: FIFO word with byte k = k (0x3f…00), `start` at edge E;
  - required: pop in E+1, 8 beats E+3..E+10;
  - first beat `row_data`=0x3f3e3d3c3b3a3938, `row_index`=7; last beat 0x0706050403020100, `row_index`=0;
  - `load_done` in E+11.
- Backpressure: `row_ready`=0 for 3 cycles while `row_index`=5 → beat held unchanged, `load_done` at E+14.
- Empty FIFO:
  - `start` with `fifo_empty`=1 → no pop, `busy`=1;
  - deassert `fifo_empty` at edge F → `fifo_read_enable` in cycle F+1.
- Queued request:
  - second `start` during SHIFT → exactly one further pop, issued the cycle after the first load's IDLE;
  - a third `start` in that window is ignored (2 pops total).
- Reset at beat `row_index`=4 → outputs 0 next cycle; a new `start` pops the next FIFO entry, not the aborted one.
